// File: rtl/ring_monitor.sv
// Ring counter checker: tracks the one-hot rotation, counts wraps, flags faults and pulses reinit_o.
// Latency: ring_i is reflected on pos_o/err_o one edge later. No backpressure: a sample is consumed every cycle.
module ring_monitor #(
  parameter int N          = 4,
  parameter int ROT_W      = 8,
  parameter int REINIT_CYC = 2,
  localparam int PW        = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             step_i,
  input  logic [N-1:0]     ring_i,
  input  logic             auto_i,
  input  logic             ack_i,
  output logic [PW-1:0]    pos_o,
  output logic             valid_o,
  output logic [ROT_W-1:0] rot_o,
  output logic             err_o,
  output logic [3:0]       err_cnt_o,
  output logic             reinit_o
);

  localparam int RCW = $clog2(REINIT_CYC + 1);
  localparam logic [RCW-1:0] RC_LAST = RCW'(REINIT_CYC - 1);

  typedef enum logic [1:0] {IDLE, TRACK, FAULT, REINIT} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     ring_q;
  logic             step_q;
  logic [RCW-1:0]   rc_q, rc_d;
  logic [PW-1:0]    pos_d;
  logic             valid_d, err_d, reinit_d;
  logic [ROT_W-1:0] rot_d;
  logic [3:0]       cnt_d;

  logic [N-1:0]  exp_ring;
  logic          onehot;
  logic [PW-1:0] idx;

  // The ring shifts at the end of a stepped cycle, so the prediction is built from last cycle's sample.
  assign exp_ring = step_q ? {ring_q[N-2:0], ring_q[N-1]} : ring_q;
  assign onehot   = (ring_i != '0) && ((ring_i & (ring_i - 1'b1)) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (ring_i[i]) idx = PW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_o;
    valid_d  = valid_o;
    rot_d    = rot_o;
    err_d    = err_o;
    cnt_d    = err_cnt_o;
    reinit_d = reinit_o;
    rc_d     = rc_q;
    // Clear comes first so a fault on the same edge overrides it.
    if (ack_i) err_d = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d  = 1'b0;
        reinit_d = 1'b0;
        if (onehot) begin
          state_d = TRACK;
          pos_d   = idx;
          valid_d = 1'b1;
        end
      end
      TRACK: begin
        if (onehot && (ring_i == exp_ring)) begin
          pos_d   = idx;
          valid_d = 1'b1;
          if (step_q && ring_q[N-1] && ring_i[0]) rot_d = rot_o + 1'b1;
        end else begin
          state_d = FAULT;
          err_d   = 1'b1;
          valid_d = 1'b0;
          if (err_cnt_o != 4'hF) cnt_d = err_cnt_o + 4'd1;
        end
      end
      FAULT: begin
        valid_d = 1'b0;
        if (auto_i || ack_i) begin
          state_d  = REINIT;
          reinit_d = 1'b1;
          rc_d     = '0;
        end
      end
      REINIT: begin
        valid_d = 1'b0;
        if (rc_q == RC_LAST) begin
          state_d  = IDLE;
          reinit_d = 1'b0;
        end else begin
          rc_d = rc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q   <= IDLE;
      ring_q    <= '0;
      step_q    <= 1'b0;
      rc_q      <= '0;
      pos_o     <= '0;
      valid_o   <= 1'b0;
      rot_o     <= '0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
      reinit_o  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ring_q    <= ring_i;
      step_q    <= step_i;
      rc_q      <= rc_d;
      pos_o     <= pos_d;
      valid_o   <= valid_d;
      rot_o     <= rot_d;
      err_o     <= err_d;
      err_cnt_o <= cnt_d;
      reinit_o  <= reinit_d;
    end
  end

endmodule

// File: tb/tb_ring_monitor.sv
// Directed bench for ring_monitor (N=4, ROT_W=8, REINIT_CYC=2) with hand-derived expectations.
module tb_ring_monitor;

  logic       clk_i = 1'b0;
  logic       clr_i;
  logic       step_i;
  logic [3:0] ring_i;
  logic       auto_i;
  logic       ack_i;
  logic [1:0] pos_o;
  logic       valid_o;
  logic [7:0] rot_o;
  logic       err_o;
  logic [3:0] err_cnt_o;
  logic       reinit_o;

  int n_vec = 0;
  int n_err = 0;

  ring_monitor #(.N(4), .ROT_W(8), .REINIT_CYC(2)) dut (
    .clk_i     (clk_i),
    .clr_i     (clr_i),
    .step_i    (step_i),
    .ring_i    (ring_i),
    .auto_i    (auto_i),
    .ack_i     (ack_i),
    .pos_o     (pos_o),
    .valid_o   (valid_o),
    .rot_o     (rot_o),
    .err_o     (err_o),
    .err_cnt_o (err_cnt_o),
    .reinit_o  (reinit_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Drive one sample, clock it in, settle just after the edge.
  task automatic cyc(input logic [3:0] r, input logic s);
    ring_i = r;
    step_i = s;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    clr_i  = 1'b1;
    step_i = 1'b0;
    ring_i = 4'b0000;
    auto_i = 1'b1;
    ack_i  = 1'b0;
    #3;
    check("rst_pos", pos_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_rot", rot_o, 0);
    check("rst_err", err_o, 0);
    check("rst_cnt", err_cnt_o, 0);
    check("rst_reinit", reinit_o, 0);
    @(posedge clk_i);
    #1;
    clr_i = 1'b0;

    // 1: lock on and follow a full rotation
    cyc(4'b0001, 1'b1);
    check("t1_pos0", pos_o, 0);
    check("t1_valid", valid_o, 1);
    cyc(4'b0010, 1'b1); check("t1_pos1", pos_o, 1);
    cyc(4'b0100, 1'b1); check("t1_pos2", pos_o, 2);
    cyc(4'b1000, 1'b1); check("t1_pos3", pos_o, 3);
    check("t1_rot_pre", rot_o, 0);
    cyc(4'b0001, 1'b1);
    check("t1_pos_wrap", pos_o, 0);
    check("t1_rot", rot_o, 1);
    check("t1_err", err_o, 0);

    // 2: two-hot pattern, auto recovery
    cyc(4'b0110, 1'b1);
    check("t2_err", err_o, 1);
    check("t2_cnt", err_cnt_o, 1);
    check("t2_valid", valid_o, 0);
    check("t2_pos_hold", pos_o, 0);
    check("t2_reinit_f", reinit_o, 0);
    cyc(4'b0000, 1'b0); check("t2_reinit1", reinit_o, 1);
    cyc(4'b0000, 1'b0); check("t2_reinit2", reinit_o, 1);
    cyc(4'b0000, 1'b0); check("t2_reinit_end", reinit_o, 0);
    check("t2_idle_valid", valid_o, 0);
    check("t2_err_sticky", err_o, 1);

    // 3: holding without a step is legal; shifting without one is not
    ack_i = 1'b1;
    cyc(4'b0100, 1'b0);
    ack_i = 1'b0;
    check("t3_ack_idle", err_o, 0);
    check("t3_pos", pos_o, 2);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0100, 1'b0);
      check("t3_hold_pos", pos_o, 2);
      check("t3_hold_valid", valid_o, 1);
      check("t3_hold_err", err_o, 0);
    end
    cyc(4'b1000, 1'b0);
    check("t3_spurious_err", err_o, 1);
    check("t3_cnt", err_cnt_o, 2);
    check("t3_pos_hold", pos_o, 2);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    check("t3_back_idle", reinit_o, 0);

    // 4: missed step, manual acknowledge
    cyc(4'b0001, 1'b1);
    check("t4_track", valid_o, 1);
    auto_i = 1'b0;
    cyc(4'b0001, 1'b1);
    check("t4_missed_err", err_o, 1);
    check("t4_cnt", err_cnt_o, 3);
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0000, 1'b0);
      check("t4_wait_reinit", reinit_o, 0);
      check("t4_wait_err", err_o, 1);
    end
    ack_i = 1'b1;
    cyc(4'b0000, 1'b0);
    ack_i = 1'b0;
    check("t4_ack_err", err_o, 0);
    check("t4_reinit1", reinit_o, 1);
    cyc(4'b0000, 1'b0); check("t4_reinit2", reinit_o, 1);
    cyc(4'b0000, 1'b0); check("t4_reinit_end", reinit_o, 0);
    cyc(4'b0000, 1'b0); check("t4_idle_valid", valid_o, 0);
    auto_i = 1'b1;

    // ack on the same edge as a new fault: set wins
    cyc(4'b0001, 1'b1);
    ack_i = 1'b1;
    cyc(4'b0000, 1'b1);
    ack_i = 1'b0;
    check("t4_set_wins", err_o, 1);
    check("t4_cnt4", err_cnt_o, 4);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);

    // 5: rotation counter wrap and fault counter saturation
    #2;
    clr_i = 1'b1;
    #2;
    clr_i = 1'b0;
    check("t5_rot_clr", rot_o, 0);
    cyc(4'b0001, 1'b1);
    for (int k = 1; k <= 4 * 255; k++) cyc(4'b0001 << (k % 4), 1'b1);
    check("t5_rot255", rot_o, 255);
    for (int k = 4 * 255 + 1; k <= 4 * 256; k++) cyc(4'b0001 << (k % 4), 1'b1);
    check("t5_rot_wrap", rot_o, 0);
    check("t5_valid", valid_o, 1);
    for (int f = 1; f <= 16; f++) begin
      cyc(4'b0000, 1'b1);
      if (f == 1)  check("t5_cnt1", err_cnt_o, 1);
      if (f == 15) check("t5_cnt15", err_cnt_o, 15);
      if (f == 16) check("t5_cnt_sat", err_cnt_o, 15);
      cyc(4'b0000, 1'b0);
      cyc(4'b0000, 1'b0);
      cyc(4'b0000, 1'b0);
      cyc(4'b0001, 1'b1);
    end
    check("t5_rot_kept", rot_o, 0);

    // 6: asynchronous clear mid-TRACK and mid-REINIT
    check("t6_pre_valid", valid_o, 1);
    clr_i = 1'b1;
    #2;
    check("t6_trk_valid", valid_o, 0);
    check("t6_trk_cnt", err_cnt_o, 0);
    check("t6_trk_err", err_o, 0);
    check("t6_trk_pos", pos_o, 0);
    #1;
    clr_i = 1'b0;
    cyc(4'b0100, 1'b1);
    check("t6_relock_pos", pos_o, 2);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b0);
    check("t6_in_reinit", reinit_o, 1);
    clr_i = 1'b1;
    #2;
    check("t6_rei_reinit", reinit_o, 0);
    check("t6_rei_err", err_o, 0);
    check("t6_rei_cnt", err_cnt_o, 0);
    check("t6_rei_valid", valid_o, 0);
    #1;
    clr_i = 1'b0;
    cyc(4'b0000, 1'b0);
    check("t6_stay_idle", reinit_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
